cond_unit_vec: RTL and testbench

Parametrised condition unit for the vector ASIP execute stage. Holds a registered per-lane flag file: Zero and Negative per lane, plus a scalar Carry. It evaluates a selectable condition code against those flags to gate branches and scalar/vector writebacks, and produces per-lane predicated write enables. A taken branch starts a fixed-length flush sequence that squashes the wrong-path instructions behind it.

---
 rtl/cond_unit_vec.sv | 222 ++++++++++++++++++++++
 tb/tb_cond_unit_vec.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_vec.sv
// -----------------------------------------------------------------------------
// cond_unit_vec
//
// Condition unit for the vector execute stage. It holds a registered flag file
// (one Zero and one Negative flag per lane, plus a scalar Carry) and evaluates
// a selectable condition code against it. The result gates branches, scalar
// writebacks, memory writes and the per-lane vector write enables.
//
// A taken branch starts a fixed-length flush sequence. While it runs, the
// wrong-path instructions behind the branch are squashed. Squashing forces all
// write and branch outputs to 0 and blocks flag capture.
//
// Parameters
//   LANES        number of vector lanes (>= 1)
//   OPW          opcode width
//   BRL_OP       branch-and-link opcode; selects the link value after the ALU
//   FLUSH_CYCLES flush length after a taken branch (0 = no flush)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous reset, active low
//   flagUpdate     capture ALU flags at this edge (IDLE only)
//   aluZero/aluNeg per-lane zero / sign result from the ALU
//   aluCarry       scalar carry out from the ALU
//   PCS            instruction in E is a branch
//   regW           instruction requests a register write
//   memWriteSrc    instruction requests a memory write
//   predMode       1 = predicate lane writes by the lane zero flags
//   condSel        condition code
//   opcodeE        execute-stage opcode
//   PCSrc          take branch target (combinational)
//   RegWrite       gated scalar register write (combinational)
//   memWrite       gated memory write (combinational)
//   laneWriteEn    gated per-lane vector write (combinational)
//   postAluMuxSel  select link value after the ALU (combinational)
//   flush          squash fetch/decode (registered)
//   zeroFlags      registered zero flags, for debug
// -----------------------------------------------------------------------------
module cond_unit_vec #(
    parameter int                LANES        = 4,
    parameter int                OPW          = 4,
    parameter logic [OPW-1:0]    BRL_OP       = 4'b1001,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flagUpdate,
    input  logic [LANES-1:0]     aluZero,
    input  logic [LANES-1:0]     aluNeg,
    input  logic                 aluCarry,
    input  logic                 PCS,
    input  logic                 regW,
    input  logic                 memWriteSrc,
    input  logic                 predMode,
    input  logic [2:0]           condSel,
    input  logic [OPW-1:0]       opcodeE,
    output logic                 PCSrc,
    output logic                 RegWrite,
    output logic                 memWrite,
    output logic [LANES-1:0]     laneWriteEn,
    output logic                 postAluMuxSel,
    output logic                 flush,
    output logic [LANES-1:0]     zeroFlags
);

    // The counter must hold FLUSH_CYCLES. It stays one bit wide when the flush
    // is disabled, so the declaration never collapses to zero width.
    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Condition codes
    localparam logic [2:0] CC_AL = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_NE = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_AZ = 3'b101;
    localparam logic [2:0] CC_CS = 3'b110;
    localparam logic [2:0] CC_NV = 3'b111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q, flush_d;
    logic [LANES-1:0]   zf_q, zf_d;
    logic [LANES-1:0]   nf_q, nf_d;
    logic               cf_q, cf_d;

    // -------------------------------------------------------------------------
    // Condition evaluation (registered flags only)
    // -------------------------------------------------------------------------
    logic all_z;
    logic any_z;
    logic neg;
    logic pass;
    logic idle;
    logic act;

    assign all_z = &zf_q;
    assign any_z = |zf_q;
    assign neg   = nf_q[0];
    assign idle  = (state_q == IDLE);

    always_comb begin
        pass = 1'b0;
        unique case (condSel)
            CC_AL:   pass = 1'b1;
            CC_EQ:   pass = all_z;
            CC_NE:   pass = ~all_z;
            CC_LT:   pass = neg;
            CC_GE:   pass = ~neg;
            CC_AZ:   pass = any_z;
            CC_CS:   pass = cf_q;
            CC_NV:   pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

    // While a flush runs, the instruction in E is on the wrong path.
    // Everything it would do is suppressed, including a branch.
    assign act = pass & idle;

    // -------------------------------------------------------------------------
    // Gated outputs (combinational, zero latency)
    // -------------------------------------------------------------------------
    logic pc_src;
    logic reg_write;

    assign pc_src        = PCS & act;
    assign reg_write     = regW & act;
    assign PCSrc         = pc_src;
    assign RegWrite      = reg_write;
    assign memWrite      = memWriteSrc & act;
    assign postAluMuxSel = pc_src & (opcodeE == BRL_OP);

    // When predication is on, a lane whose zero flag is set keeps its old value.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
        assign laneWriteEn[gi] = reg_write & (predMode ? ~zf_q[gi] : 1'b1);
    end

    assign flush     = flush_q;
    assign zeroFlags = zf_q;

    // -------------------------------------------------------------------------
    // Flag file next state: capture only in IDLE
    // -------------------------------------------------------------------------
    always_comb begin
        zf_d = zf_q;
        nf_d = nf_q;
        cf_d = cf_q;
        if (flagUpdate && idle) begin
            zf_d = aluZero;
            nf_d = aluNeg;
            cf_d = aluCarry;
        end
    end

    // -------------------------------------------------------------------------
    // Flush FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pc_src && (FLUSH_CYCLES > 0)) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                // A branch seen here was squashed above, so it cannot
                // restart the counter.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Register flush so the flush output comes straight from a flop.
        flush_d = (state_d == FLUSH);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            zf_q    <= '0;
            nf_q    <= '0;
            cf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            cf_q    <= cf_d;
        end
    end

    // The sign flags of lanes above 0 are kept in the flag file. No current
    // condition code reads them.
    logic unused_nf;
    assign unused_nf = ^nf_q;

endmodule

// File: tb/tb_cond_unit_vec.sv
// -----------------------------------------------------------------------------
// tb_cond_unit_vec
//
// Directed bench for cond_unit_vec. dut_a uses the default parameters
// (4 lanes, 2-cycle flush). dut_b is built with FLUSH_CYCLES = 0. Both DUTs
// share the same stimulus.
//
// The driver applies inputs one time unit after each rising edge. It pushes
// the hand-computed expected outputs for that cycle into a queue. The monitor
// pops one entry at each falling edge and compares it with the selected DUT.
// -----------------------------------------------------------------------------
module tb_cond_unit_vec;

    logic       clk = 1'b0;
    logic       reset;
    logic       flagUpdate;
    logic [3:0] aluZero;
    logic [3:0] aluNeg;
    logic       aluCarry;
    logic       PCS;
    logic       regW;
    logic       memWriteSrc;
    logic       predMode;
    logic [2:0] condSel;
    logic [3:0] opcodeE;

    logic       a_pcsrc, a_regw, a_memw, a_post, a_flush;
    logic [3:0] a_lwe, a_zf;
    logic       b_pcsrc, b_regw, b_memw, b_post, b_flush;
    logic [3:0] b_lwe, b_zf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cond_unit_vec dut_a (
        .clk(clk), .reset(reset), .flagUpdate(flagUpdate),
        .aluZero(aluZero), .aluNeg(aluNeg), .aluCarry(aluCarry),
        .PCS(PCS), .regW(regW), .memWriteSrc(memWriteSrc),
        .predMode(predMode), .condSel(condSel), .opcodeE(opcodeE),
        .PCSrc(a_pcsrc), .RegWrite(a_regw), .memWrite(a_memw),
        .laneWriteEn(a_lwe), .postAluMuxSel(a_post), .flush(a_flush),
        .zeroFlags(a_zf)
    );

    cond_unit_vec #(.FLUSH_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .flagUpdate(flagUpdate),
        .aluZero(aluZero), .aluNeg(aluNeg), .aluCarry(aluCarry),
        .PCS(PCS), .regW(regW), .memWriteSrc(memWriteSrc),
        .predMode(predMode), .condSel(condSel), .opcodeE(opcodeE),
        .PCSrc(b_pcsrc), .RegWrite(b_regw), .memWrite(b_memw),
        .laneWriteEn(b_lwe), .postAluMuxSel(b_post), .flush(b_flush),
        .zeroFlags(b_zf)
    );

    typedef struct {
        string      name;
        bit         dut;     // 0 = dut_a, 1 = dut_b
        logic       pc, rw, mw, post, fl;
        logic [3:0] lwe, zf;
    } exp_t;

    exp_t sb_q[$];

    // ---------------------------------------------------------------- driver
    task automatic drive(input logic fu, input logic [3:0] az, input logic [3:0] an,
                         input logic ac, input logic pcs, input logic rw,
                         input logic mw, input logic pm, input logic [2:0] cs,
                         input logic [3:0] op);
        flagUpdate  = fu;
        aluZero     = az;
        aluNeg      = an;
        aluCarry    = ac;
        PCS         = pcs;
        regW        = rw;
        memWriteSrc = mw;
        predMode    = pm;
        condSel     = cs;
        opcodeE     = op;
    endtask

    task automatic expect_cyc(input string nm, input bit d, input logic pc,
                              input logic rw, input logic mw, input logic post,
                              input logic fl, input logic [3:0] lwe,
                              input logic [3:0] zf);
        exp_t e;
        e.name = nm; e.dut = d; e.pc = pc; e.rw = rw; e.mw = mw;
        e.post = post; e.fl = fl; e.lwe = lwe; e.zf = zf;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // --------------------------------------------------------------- monitor
    task automatic cmp(input string nm, input string f,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got %b expected %b", nm, f, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.dut == 1'b0) begin
                    cmp(e.name, "PCSrc",         {3'b0, a_pcsrc}, {3'b0, e.pc});
                    cmp(e.name, "RegWrite",      {3'b0, a_regw},  {3'b0, e.rw});
                    cmp(e.name, "memWrite",      {3'b0, a_memw},  {3'b0, e.mw});
                    cmp(e.name, "postAluMuxSel", {3'b0, a_post},  {3'b0, e.post});
                    cmp(e.name, "flush",         {3'b0, a_flush}, {3'b0, e.fl});
                    cmp(e.name, "laneWriteEn",   a_lwe,           e.lwe);
                    cmp(e.name, "zeroFlags",     a_zf,            e.zf);
                end else begin
                    cmp(e.name, "PCSrc",         {3'b0, b_pcsrc}, {3'b0, e.pc});
                    cmp(e.name, "RegWrite",      {3'b0, b_regw},  {3'b0, e.rw});
                    cmp(e.name, "memWrite",      {3'b0, b_memw},  {3'b0, e.mw});
                    cmp(e.name, "postAluMuxSel", {3'b0, b_post},  {3'b0, e.post});
                    cmp(e.name, "flush",         {3'b0, b_flush}, {3'b0, e.fl});
                    cmp(e.name, "laneWriteEn",   b_lwe,           e.lwe);
                    cmp(e.name, "zeroFlags",     b_zf,            e.zf);
                end
                $display("txn %-12s dut=%s checks=%0d errors=%0d",
                         e.name, e.dut ? "b" : "a", checks, errors);
            end
        end
    end

    // -------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        reset = 1'b0;
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);
        tick();

        // Reset state
        expect_cyc("rst", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        reset = 1'b1;

        // Flags are 0 after reset: EQ fails, NE is taken, then a 2-cycle flush
        drive(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b001, 4'b0000);
        expect_cyc("eq_fail", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b010, 4'b0000);
        expect_cyc("ne_taken", 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("ne_flush1", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        tick();
        expect_cyc("ne_flush2", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        tick();
        expect_cyc("ne_done", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();

        // Predication: zf=0101 masks lanes 0 and 2
        drive(1, 4'b0101, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("cap_z", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 1, 3'b000, 4'b0000);
        expect_cyc("pred_on", 0, 0, 1, 0, 0, 0, 4'b1010, 4'b0101);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 0, 3'b000, 4'b0000);
        expect_cyc("pred_off", 0, 0, 1, 0, 0, 0, 4'b1111, 4'b0101);
        tick();

        // Branch-and-link, then squashed wrong-path cycles (flag capture blocked)
        drive(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b000, 4'b1001);
        expect_cyc("brl", 0, 1, 0, 0, 1, 0, 4'b0000, 4'b0101);
        tick();
        drive(1, 4'b1111, 4'b0000, 0, 1, 1, 1, 0, 3'b000, 4'b1001);
        expect_cyc("brl_sq1", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0101);
        tick();
        expect_cyc("brl_sq2", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0101);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 1, 1, 0, 3'b000, 4'b0000);
        expect_cyc("brl_resume", 0, 0, 1, 1, 0, 0, 4'b1111, 4'b0101);
        tick();

        // Flag ordering: branch uses old all-zero flags, new flags are captured
        drive(1, 4'b1111, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("set_allz", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0101);
        tick();
        drive(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b001, 4'b0000);
        expect_cyc("ord_branch", 0, 1, 0, 0, 0, 0, 4'b0000, 4'b1111);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 1, 0, 0, 3'b001, 4'b0000);
        expect_cyc("ord_fl1", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        tick();
        expect_cyc("ord_fl2", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        tick();
        expect_cyc("ord_eq0", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();

        // Capture sign/carry, take an LT branch, then reset in mid-flush
        drive(1, 4'b0011, 4'b0001, 1, 0, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("cap_neg", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b011, 4'b0000);
        expect_cyc("lt_taken", 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0011);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("rst_fl1", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0011);
        tick();
        reset = 1'b0;
        expect_cyc("rst_abort", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        reset = 1'b1;
        drive(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("post_rst_br", 0, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("prb_fl1", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        tick();
        expect_cyc("prb_fl2", 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b110, 4'b0000);
        expect_cyc("cs_cleared", 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();

        // FLUSH_CYCLES = 0 build
        reset = 1'b0;
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("b_rst", 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        reset = 1'b1;
        drive(0, 4'b0000, 4'b0000, 0, 1, 0, 0, 0, 3'b000, 4'b0000);
        expect_cyc("b_br1", 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        expect_cyc("b_br2", 1, 1, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        drive(1, 4'b0000, 4'b0000, 1, 1, 0, 0, 0, 3'b110, 4'b0000);
        expect_cyc("b_cs_old", 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 1, 1, 0, 0, 3'b110, 4'b0000);
        expect_cyc("b_cs_pass", 1, 1, 1, 0, 0, 0, 4'b1111, 4'b0000);
        tick();
        drive(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 3'b000, 4'b0000);

        // Let the monitor drain the scoreboard
        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain %0d entries left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
